// File: rtl/comm_unit.sv
// comm_unit: UART packet transceiver between the host serial line and the
// matrix-multiply datapath. Packets are a size byte N, then N value bytes,
// then N index bytes. In load mode they are assembled into rx_data. In send
// mode tx_data is serialized. The 8N1 receiver and transmitter run from clk
// with a fixed BAUD_DIV clocks per bit.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   op           0 = load (receive), 1 = send; sampled only in IDLE
//   start        in load mode, drops a partial packet and re-arms
//   rx / tx      host serial lines, idle high
//   tx_data      packet to send: [135:128] N, [127:64] values, [63:0] indices
//   rx_data      last received packet, same layout
//   tx_complete  set when a send finishes, cleared when the next packet starts
//   rx_complete  set when a load finishes, cleared when the next packet starts
//   busy         packet in progress
//
// Optional build macro COMM_FRAME_CHECK_EN: when it is defined, a frame whose
// stop bit samples 0 is dropped and yields no byte.
module comm_unit #(
    parameter int BAUD_DIV  = 5,
    parameter int MAX_BYTES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op,
    input  logic         start,
    input  logic         rx,
    input  logic [135:0] tx_data,
    output logic         tx,
    output logic         tx_complete,
    output logic         rx_complete,
    output logic [135:0] rx_data,
    output logic         busy
);
    localparam int          IW        = $clog2(MAX_BYTES);
    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [3:0] {
        IDLE, RX_SIZE, RX_VAL, RX_IDX, RX_DONE, TX_SIZE, TX_VAL, TX_IDX, TX_DONE
    } state_t;

    state_t state, state_n;

    // ---------------- receiver ----------------
    logic        rx_meta, rx_s, rx_prev, r_active, r_tick, stop_ok, rx_edge, rx_stb;
    logic [3:0]  r_bit;     // 0 = start check, 1..8 = data, 9 = stop
    logic [15:0] r_baud;
    logic [7:0]  r_shift, rx_byte;

    assign rx_edge = !r_active && rx_prev && !rx_s;
    // The start bit is re-checked at half a bit; later samples are a full bit apart.
    assign r_tick  = r_active && (r_baud == ((r_bit == 4'd0) ? HALF_LAST : BIT_LAST));
`ifdef COMM_FRAME_CHECK_EN
    assign stop_ok = rx_s;
`else
    assign stop_ok = 1'b1;
`endif
    // The strobe fires in the same cycle as the mid-stop sample.
    assign rx_stb  = r_tick && (r_bit == 4'd9) && stop_ok;
    assign rx_byte = r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            r_active <= 1'b0;
            r_bit    <= '0;
            r_baud   <= '0;
            r_shift  <= '0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            if (rx_edge) begin
                r_active <= 1'b1;
                r_bit    <= '0;
                r_baud   <= '0;
            end else if (r_tick) begin
                r_baud <= '0;
                if (r_bit == 4'd0) begin
                    if (rx_s) r_active <= 1'b0;   // glitch, not a start bit
                    else      r_bit    <= 4'd1;
                end else if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_shift <= {rx_s, r_shift[7:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else if (r_active) begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

    // ---------------- transmitter ----------------
    logic        t_busy, t_load, t_end;
    logic [7:0]  t_byte;
    logic [9:0]  t_shift;
    logic [3:0]  t_bit;
    logic [15:0] t_baud;

    // t_end marks the last clock of a stop bit. Loading the next byte in that
    // cycle keeps the frames back-to-back.
    assign t_end = t_busy && (t_baud == BIT_LAST) && (t_bit == 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx      <= 1'b1;
            t_busy  <= 1'b0;
            t_shift <= '1;
            t_bit   <= '0;
            t_baud  <= '0;
        end else if (t_load) begin
            t_shift <= {1'b1, t_byte, 1'b0};
            tx      <= 1'b0;
            t_bit   <= '0;
            t_baud  <= '0;
            t_busy  <= 1'b1;
        end else if (t_busy) begin
            if (t_baud == BIT_LAST) begin
                t_baud <= '0;
                if (t_bit == 4'd9) begin
                    t_busy <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    t_bit   <= t_bit + 4'd1;
                    t_shift <= {1'b1, t_shift[9:1]};
                    tx      <= t_shift[1];
                end
            end else begin
                t_baud <= t_baud + 16'd1;
            end
        end
    end

    // ---------------- packet FSM ----------------
    logic [7:0]                  n;
    logic [IW-1:0]               cnt, pos;
    logic [MAX_BYTES-1:0][7:0]   val_buf, idx_buf;
    logic                        last;

    function automatic logic [7:0] clamp_n(input logic [7:0] b);
        return (b > 8'(MAX_BYTES)) ? 8'(MAX_BYTES) : b;
    endfunction

    assign pos  = IW'(MAX_BYTES - 1) - cnt;   // first byte lands in the top slot
    assign last = ((8'(cnt) + 8'd1) == n);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        t_load  = 1'b0;
        t_byte  = '0;
        case (state)
            IDLE:    if (op)           state_n = TX_SIZE;
                     else if (rx_edge) state_n = RX_SIZE;
            RX_SIZE: if (start)        state_n = IDLE;
                     else if (rx_stb)  state_n = (rx_byte == 8'd0) ? RX_DONE : RX_VAL;
            RX_VAL:  if (start)                 state_n = IDLE;
                     else if (rx_stb && last)   state_n = RX_IDX;
            RX_IDX:  if (start)                 state_n = IDLE;
                     else if (rx_stb && last)   state_n = RX_DONE;
            RX_DONE: state_n = IDLE;
            TX_SIZE: begin
                t_load  = 1'b1;
                t_byte  = n;
                state_n = (n == 8'd0) ? TX_DONE : TX_VAL;
            end
            TX_VAL: if (t_end) begin
                t_load = 1'b1;
                t_byte = val_buf[pos];
                if (last) state_n = TX_IDX;
            end
            TX_IDX: if (t_end) begin
                t_load = 1'b1;
                t_byte = idx_buf[pos];
                if (last) state_n = TX_DONE;
            end
            TX_DONE: if (t_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n           <= '0;
            cnt         <= '0;
            val_buf     <= '0;
            idx_buf     <= '0;
            rx_data     <= '0;
            rx_complete <= 1'b0;
            tx_complete <= 1'b0;
        end else begin
            if (state == IDLE && state_n != IDLE) begin
                rx_complete <= 1'b0;
                tx_complete <= 1'b0;
                cnt         <= '0;
            end
            case (state)
                IDLE: if (op) begin
                    n       <= clamp_n(tx_data[135:128]);
                    val_buf <= tx_data[127:64];
                    idx_buf <= tx_data[63:0];
                end
                RX_SIZE: if (rx_stb && !start) begin
                    n       <= clamp_n(rx_byte);
                    val_buf <= '0;
                    idx_buf <= '0;
                    cnt     <= '0;
                end
                RX_VAL: if (rx_stb && !start) begin
                    val_buf[pos] <= rx_byte;
                    cnt          <= last ? '0 : cnt + 1'b1;
                end
                RX_IDX: if (rx_stb && !start) begin
                    idx_buf[pos] <= rx_byte;
                    cnt          <= last ? '0 : cnt + 1'b1;
                end
                RX_DONE: begin
                    rx_data     <= {n, val_buf, idx_buf};
                    rx_complete <= 1'b1;
                end
                TX_VAL, TX_IDX: if (t_end) cnt <= last ? '0 : cnt + 1'b1;
                TX_DONE: if (t_end) tx_complete <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comm_unit.sv
module tb_comm_unit;
    logic         clk = 1'b0;
    logic         reset, op, start, rx;
    logic [135:0] tx_data;
    logic         tx, tx_complete, rx_complete, busy;
    logic [135:0] rx_data;

    int total = 0;
    int bad   = 0;

    logic [135:0] rx_exp_q[$];
    logic [7:0]   tx_exp_q[$];
    logic [135:0] last_rx = '0;

    comm_unit dut (
        .clk(clk), .reset(reset), .op(op), .start(start), .rx(rx),
        .tx_data(tx_data), .tx(tx), .tx_complete(tx_complete),
        .rx_complete(rx_complete), .rx_data(rx_data), .busy(busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int b);
        return (b > 8) ? 8 : b;
    endfunction

    // ---- monitor: every rising rx_complete must match the oldest expected packet
    logic rxc_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_complete === 1'b1 && rxc_prev !== 1'b1) begin
            if (rx_exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rx_unexpected: got rx_data %h want no completion", rx_data);
            end else begin
                check("rx_data", rx_data, rx_exp_q.pop_front());
            end
        end
        rxc_prev = rx_complete;
    end

    // ---- reference 8N1 receiver on tx, sampling mid-bit
    initial begin : tx_ref
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (5) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (5) @(negedge clk);
                    check("tx_stop_bit", {135'd0, tx}, 136'd1);
                    if (tx_exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL tx_unexpected_byte: got %h want none", b);
                    end else begin
                        check("tx_byte", {128'd0, b}, {128'd0, tx_exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // ---- host-side driver; called at a negedge
    task automatic host_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (5) @(negedge clk);
        end
        rx = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Sends a full load packet and queues the expected rx_data.
    task automatic load_pkt(input logic [7:0] sz, input logic [63:0] vals, input logic [63:0] idxs);
        int          k;
        logic [63:0] mask;
        logic [135:0] e;
        k    = clampi(int'(sz));
        mask = ~64'h0 << (64 - 8 * k);
        e    = {8'(k), vals & mask, idxs & mask};
        rx_exp_q.push_back(e);
        last_rx = e;
        host_byte(sz);
        for (int i = 0; i < k; i++) host_byte(vals[63 - 8 * i -: 8]);
        for (int i = 0; i < k; i++) host_byte(idxs[63 - 8 * i -: 8]);
    endtask

    task automatic wait_rx_drain(input string name);
        int c;
        c = 0;
        while (rx_exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (rx_exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, rx_exp_q.size());
            rx_exp_q.delete();
        end
        check({name, "_rx_complete"}, {135'd0, rx_complete}, 136'd1);
        check({name, "_busy"}, {135'd0, busy}, 136'd0);
    endtask

    task automatic send_pkt(input logic [135:0] d, input string name);
        int k, cyc, dur;
        logic [63:0] v, x;
        k = clampi(int'(d[135:128]));
        v = d[127:64];
        x = d[63:0];
        tx_exp_q.push_back(8'(k));
        for (int i = 0; i < k; i++) tx_exp_q.push_back(v[63 - 8 * i -: 8]);
        for (int i = 0; i < k; i++) tx_exp_q.push_back(x[63 - 8 * i -: 8]);
        dur = (1 + 2 * k) * 10 * 5;
        tx_data = d;
        op = 1'b1;
        @(negedge clk);
        op = 1'b0;
        cyc = 1;
        while (tx_complete !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc < dur || cyc > dur + 3) begin
            bad++;
            $display("FAIL %s_duration: got %0d clocks want %0d..%0d", name, cyc, dur, dur + 3);
        end
        check({name, "_busy"}, {135'd0, busy}, 136'd0);
        repeat (3) @(negedge clk);
        check({name, "_bytes_left"}, 136'(tx_exp_q.size()), 136'd0);
        tx_exp_q.delete();
        check({name, "_tx_idle"}, {135'd0, tx}, 136'd1);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = 1'b0; start = 1'b0; rx = 1'b1; tx_data = '0;
        repeat (40) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_tx", {135'd0, tx}, 136'd1);
        check("reset_busy", {135'd0, busy}, 136'd0);
        check("reset_txc", {135'd0, tx_complete}, 136'd0);
        check("reset_rxc", {135'd0, rx_complete}, 136'd0);
        check("reset_rx_data", rx_data, 136'd0);
        repeat (5) @(negedge clk);

        // directed load example
        load_pkt(8'h04, 64'h74FB7BFE_00000000, 64'h00000003_00000000);
        wait_rx_drain("load4");

        // full-size packet, then four back-to-back random packets
        load_pkt(8'h08, 64'h74FB7BFE978F83D7, 64'h0000000100020003);
        wait_rx_drain("load8");
        for (int p = 0; p < 4; p++)
            load_pkt(8'($urandom_range(0, 12)), {$urandom, $urandom}, {$urandom, $urandom});
        wait_rx_drain("b2b");

        // oversize and empty packets
        load_pkt(8'h0C, 64'h1122334455667788, 64'h99AABBCCDDEEFF01);
        wait_rx_drain("clamp");
        load_pkt(8'h00, 64'h0, 64'h0);
        wait_rx_drain("empty");

        // reset during the value bytes
        host_byte(8'h04);
        host_byte(8'h5A);
        host_byte(8'hA5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_rxc", {135'd0, rx_complete}, 136'd0);
        check("abort_busy", {135'd0, busy}, 136'd0);
        last_rx = '0;
        check("abort_rx_data", rx_data, last_rx);
        load_pkt(8'h03, 64'hC0FFEE00_00000000, 64'h01020300_00000000);
        wait_rx_drain("after_reset");

        // start pulse discards a partial packet
        host_byte(8'h03);
        host_byte(8'h77);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("start_busy", {135'd0, busy}, 136'd0);
        check("start_rx_data", rx_data, last_rx);
        load_pkt(8'h02, 64'hDEAD0000_00000000, 64'hBEEF0000_00000000);
        wait_rx_drain("after_start");

        // sends
        send_pkt({8'h04, 64'h74FB7BFE00000000, 64'h0000000300000000}, "send4");
        for (int p = 0; p < 3; p++)
            send_pkt({8'($urandom_range(0, 12)), $urandom, $urandom, $urandom, $urandom}, "send_rand");
        check("send_rxc_clear", {135'd0, rx_complete}, 136'd0);

        // load after sends still works
        load_pkt(8'h01, 64'hAB000000_00000000, 64'hCD000000_00000000);
        wait_rx_drain("final_load");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
